// File: rtl/hawk_axiwr_arb_if.sv
// hawk_axiwr_arb_if
//   Bundles the client request/response lanes, the single write port toward
//   the axiwr master, and the arbiter status outputs.
//   slave  : arbiter view (takes client requests, drives AW/W/B handshake)
//   master : environment view (clients plus axiwr master)
//   Client lane i occupies slice [i*W +: W] of each flattened request vector.
interface hawk_axiwr_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int STRB_W  = 64,
  parameter int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ*STRB_W-1:0] req_strb_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        req_done_o;
  logic [1:0]                req_bresp_o;
  logic [ADDR_W-1:0]         m_addr_o;
  logic [DATA_W-1:0]         m_data_o;
  logic [STRB_W-1:0]         m_strb_o;
  logic                      m_awvalid_o;
  logic                      m_awready_i;
  logic                      m_wvalid_o;
  logic                      m_wready_i;
  logic                      m_bvalid_i;
  logic [1:0]                m_bresp_i;
  logic                      m_bready_o;
  logic [GID_W-1:0]          grant_id_o;
  logic                      busy_o;
  logic                      tmo_err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_strb_i,
           m_awready_i, m_wready_i, m_bvalid_i, m_bresp_i,
    output req_ready_o, req_done_o, req_bresp_o,
           m_addr_o, m_data_o, m_strb_o, m_awvalid_o, m_wvalid_o, m_bready_o,
           grant_id_o, busy_o, tmo_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_strb_i,
           m_awready_i, m_wready_i, m_bvalid_i, m_bresp_i,
    input  req_ready_o, req_done_o, req_bresp_o,
           m_addr_o, m_data_o, m_strb_o, m_awvalid_o, m_wvalid_o, m_bready_o,
           grant_id_o, busy_o, tmo_err_o
  );
endinterface

// File: rtl/hawk_axiwr_arb.sv
// hawk_axiwr_arb
//   Round-robin arbiter sharing one axiwr write port among NUM_REQ clients.
//   One write outstanding at a time: a client's cacheline (addr/data/strb) is
//   captured on grant, AW and W are presented, and the B response is routed
//   back to that client. A watchdog forces an SLVERR completion if B never
//   arrives; the late B that may follow is drained silently.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : hawk_axiwr_arb_if.slave (client lanes, AW/W/B port, status)
module hawk_axiwr_arb #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int STRB_W    = 64,
  parameter int BRESP_TMO = 1024
) (
  input  logic             clk,
  input  logic             rst,
  hawk_axiwr_arb_if.slave  bus
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(BRESP_TMO) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AD   = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]        state;
  logic [GID_W-1:0]  last_grant;
  logic [GID_W-1:0]  grant_id;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              drain_q;
  logic              tmo_err_q;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [GID_W-1:0]  gnt_idx;
  logic              gnt_found;
  int                cand;
  int                sel;

  // Rotating priority: search upward from last_grant+1, first hit wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!gnt_found && bus.req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = GID_W'(cand);
      end
    end
  end

  assign sel = int'(gnt_idx);

  logic grant_fire, aw_fin, w_fin, b_take, tmo_hit, complete, stale;

  assign grant_fire = (state == S_IDLE) && gnt_found;
  // A channel counts as finished once its valid has dropped or it handshakes now.
  assign aw_fin     = !awvalid_q || bus.m_awready_i;
  assign w_fin      = !wvalid_q  || bus.m_wready_i;
  // With drain pending, any B seen belongs to the timed-out write.
  assign stale      = drain_q && bus.m_bvalid_i;
  assign b_take     = (state == S_WB) && bus.m_bvalid_i && !drain_q;
  assign tmo_hit    = (state == S_WB) && !b_take &&
                      (tmo_cnt == TMO_W'(BRESP_TMO - 1));
  assign complete   = b_take || tmo_hit;

  assign bus.req_ready_o = grant_fire ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.req_done_o  = complete   ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.req_bresp_o = b_take ? bus.m_bresp_i : (tmo_hit ? 2'b10 : 2'b00);
  assign bus.m_bready_o  = (state == S_WB) || drain_q;
  assign bus.m_awvalid_o = awvalid_q;
  assign bus.m_wvalid_o  = wvalid_q;
  assign bus.m_addr_o    = addr_q;
  assign bus.m_data_o    = data_q;
  assign bus.m_strb_o    = strb_q;
  assign bus.grant_id_o  = grant_id;
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.tmo_err_o   = tmo_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= GID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      drain_q    <= 1'b0;
      tmo_err_q  <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      // Clear first so a timeout in the same cycle re-arms drain.
      if (stale) drain_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            addr_q    <= bus.req_addr_i[sel*ADDR_W +: ADDR_W];
            data_q    <= bus.req_data_i[sel*DATA_W +: DATA_W];
            strb_q    <= bus.req_strb_i[sel*STRB_W +: STRB_W];
            grant_id  <= gnt_idx;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= S_AD;
          end
        end
        S_AD: begin
          if (awvalid_q && bus.m_awready_i) awvalid_q <= 1'b0;
          if (wvalid_q  && bus.m_wready_i)  wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            state   <= S_WB;
            tmo_cnt <= '0;
          end
        end
        S_WB: begin
          if (complete) begin
            state      <= S_IDLE;
            last_grant <= grant_id;
            tmo_cnt    <= '0;
            if (tmo_hit) begin
              tmo_err_q <= 1'b1;
              drain_q   <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
